reset_sequencer: RTL and testbench

//  Sits directly downstream of the reset synchronizer: takes the synchronized, inverted reset and

---
 rtl/reset_sequencer.sv | 130 +++++++++++++
 tb/tb_reset_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES downstream reset domains one at a time after a
// hold period, waiting for each stage's init-done (with optional timeout) and an idle gap.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES          = 4,
    parameter int unsigned HOLD_CYCLES         = 16,
    parameter int unsigned STAGE_GAP_CYCLES    = 8,
    parameter int unsigned DONE_TIMEOUT_CYCLES = 1024,
    parameter int unsigned WAIT_FOR_DONE       = 1
) (
    input  logic                          sync_clk,
    input  logic                          reset_n,
    input  logic                          soft_reset_req,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_reset,
    output logic                          sys_ready,
    output logic                          timeout_err,
    output logic [$clog2(NUM_STAGES):0]   cur_stage
);

    localparam int unsigned SW      = $clog2(NUM_STAGES) + 1;
    localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP_CYCLES) ? HOLD_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_HG > DONE_TIMEOUT_CYCLES) ? MAX_HG : DONE_TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_ALL + 1);
    localparam int unsigned TO_LAST = (DONE_TIMEOUT_CYCLES > 0) ? DONE_TIMEOUT_CYCLES - 1 : 0;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_AT = CW'(TO_LAST);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            cur_done;
    logic [SW-1:0]   next_stage;

    // Done bit of the stage currently awaited; other stages' bits are ignored.
    always_comb begin
        cur_done = 1'b0;
        if (WAIT_FOR_DONE == 0) begin
            cur_done = 1'b1;
        end else begin
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                if (cur_stage == SW'(i)) begin
                    cur_done = stage_done[i];
                end
            end
        end
    end

    assign next_stage = cur_stage + SW'(1);

    // Sequencer FSM; all outputs are updated here so they come straight from flops.
    always_ff @(posedge sync_clk) begin
        if (!reset_n || soft_reset_req) begin
            state       <= S_HOLD;
            counter     <= '0;
            cur_stage   <= '0;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (counter == HOLD_LAST) begin
                        stage_reset <= stage_reset & ~NUM_STAGES'(1);
                        counter     <= '0;
                        state       <= S_WAIT;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cur_done) begin
                        counter <= '0;
                        if (cur_stage == LAST_STAGE) begin
                            state     <= S_RUN;
                            sys_ready <= 1'b1;
                        end else if (STAGE_GAP_CYCLES != 0) begin
                            state <= S_GAP;
                        end else begin
                            stage_reset <= stage_reset & ~(NUM_STAGES'(1) << next_stage);
                            cur_stage   <= next_stage;
                        end
                    end else if ((DONE_TIMEOUT_CYCLES != 0) && (counter == TIMEOUT_AT)) begin
                        state       <= S_FAULT;
                        counter     <= '0;
                        stage_reset <= '1;
                        sys_ready   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (counter != CNT_MAX) begin
                        counter <= counter + CW'(1);
                    end
                end
                S_GAP: begin
                    // STAGE_GAP_CYCLES idle cycles, then the release on the following one.
                    if (counter == GAP_LAST) begin
                        stage_reset <= stage_reset & ~(NUM_STAGES'(1) << next_stage);
                        cur_stage   <= next_stage;
                        counter     <= '0;
                        state       <= S_WAIT;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                S_RUN: begin
                    sys_ready <= 1'b1;
                end
                S_FAULT: begin
                    stage_reset <= '1;
                    sys_ready   <= 1'b0;
                    timeout_err <= 1'b1;
                end
                default: begin
                    state   <= S_HOLD;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized runs checked against a timestamp model of the release schedule.
module tb_reset_sequencer;

    localparam int unsigned NS    = 4;
    localparam int unsigned SW    = $clog2(NS) + 1;
    localparam int          HOLD  = 16;
    localparam int          GAP_A = 8;
    localparam int          TO_A  = 64;
    localparam int          INF   = 1 << 30;

    logic          sync_clk = 1'b0;
    logic          reset_n;
    logic          soft_reset_req;
    logic [NS-1:0] done_a, done_b, rst_a, rst_b;
    logic          ready_a, ready_b, terr_a, terr_b;
    logic [SW-1:0] cur_a, cur_b;

    int checks = 0;
    int errors = 0;

    // Model timestamps (edge index after which the event is visible); INF = never.
    int ra[NS], da[NS], rb[NS], db[NS];
    int fa, fb;
    int dly[NS];

    always #5 sync_clk = ~sync_clk;

    reset_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP_CYCLES(GAP_A),
        .DONE_TIMEOUT_CYCLES(TO_A), .WAIT_FOR_DONE(1)
    ) dut_a (
        .sync_clk(sync_clk), .reset_n(reset_n), .soft_reset_req(soft_reset_req),
        .stage_done(done_a), .stage_reset(rst_a), .sys_ready(ready_a),
        .timeout_err(terr_a), .cur_stage(cur_a)
    );

    reset_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(HOLD), .STAGE_GAP_CYCLES(0),
        .DONE_TIMEOUT_CYCLES(1024), .WAIT_FOR_DONE(0)
    ) dut_b (
        .sync_clk(sync_clk), .reset_n(reset_n), .soft_reset_req(soft_reset_req),
        .stage_done(done_b), .stage_reset(rst_b), .sys_ready(ready_b),
        .timeout_err(terr_b), .cur_stage(cur_b)
    );

    task automatic check(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
        end
    endtask

    // Release schedule from the rules: hold, then per stage wait-for-done, then gap.
    task automatic compute_schedule();
        int r;
        for (int k = 0; k < int'(NS); k++) begin
            ra[k] = INF; da[k] = INF; rb[k] = INF; db[k] = INF;
        end
        fa = INF;
        fb = INF;
        r  = HOLD - 1;
        for (int k = 0; k < int'(NS); k++) begin
            ra[k] = r;
            if (dly[k] > TO_A - 1) begin
                fa = r + TO_A;
                break;
            end
            da[k] = r + 1 + dly[k];
            r = da[k] + GAP_A + 1;
        end
        r = HOLD - 1;
        for (int k = 0; k < int'(NS); k++) begin
            rb[k] = r;
            db[k] = r + 1;
            r = db[k];
        end
    endtask

    task automatic check_model(input bit which, input int e);
        logic [NS-1:0] exp_rst;
        int exp_cur, rk, f, dl;
        bit flt;
        f   = which ? fb : fa;
        dl  = which ? db[NS-1] : da[NS-1];
        flt = (e >= f);
        exp_cur = 0;
        for (int k = 0; k < int'(NS); k++) begin
            rk = which ? rb[k] : ra[k];
            exp_rst[k] = flt || (e < rk);
            if (rk <= e) exp_cur = k;
        end
        if (which) begin
            check("b.stage_reset", e, 32'(rst_b), 32'(exp_rst));
            check("b.sys_ready", e, 32'(ready_b), 32'(!flt && e >= dl));
            check("b.timeout_err", e, 32'(terr_b), 32'(flt));
            check("b.cur_stage", e, 32'(cur_b), 32'(exp_cur));
        end else begin
            check("a.stage_reset", e, 32'(rst_a), 32'(exp_rst));
            check("a.sys_ready", e, 32'(ready_a), 32'(!flt && e >= dl));
            check("a.timeout_err", e, 32'(terr_a), 32'(flt));
            check("a.cur_stage", e, 32'(cur_a), 32'(exp_cur));
        end
    endtask

    task automatic check_reset_values(input int e);
        check("rst.a.stage_reset", e, 32'(rst_a), 32'({NS{1'b1}}));
        check("rst.a.sys_ready", e, 32'(ready_a), 32'(0));
        check("rst.a.timeout_err", e, 32'(terr_a), 32'(0));
        check("rst.a.cur_stage", e, 32'(cur_a), 32'(0));
        check("rst.b.stage_reset", e, 32'(rst_b), 32'({NS{1'b1}}));
        check("rst.b.sys_ready", e, 32'(ready_b), 32'(0));
        check("rst.b.cur_stage", e, 32'(cur_b), 32'(0));
    endtask

    // Awaited stage sees 0 until its done edge; every other bit is random noise.
    task automatic drive_done(input int e);
        for (int j = 0; j < int'(NS); j++) begin
            if (e > ra[j] && e <= da[j] && e <= fa)
                done_a[j] = (e == da[j]);
            else
                done_a[j] = 1'($urandom_range(0, 1));
        end
        done_b = NS'($urandom);
    endtask

    initial begin
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        done_a         = '0;
        done_b         = '0;
        repeat (3) @(posedge sync_clk);
        @(negedge sync_clk);
        check_reset_values(-1);

        for (int run = 0; run < 14; run++) begin
            int endpt, len, kind, pick;
            for (int k = 0; k < int'(NS); k++) dly[k] = $urandom_range(0, 12);
            case (run)
                0: for (int k = 0; k < int'(NS); k++) dly[k] = 0;
                1: begin for (int k = 0; k < int'(NS); k++) dly[k] = 0; dly[1] = TO_A - 1; end
                2: begin for (int k = 0; k < int'(NS); k++) dly[k] = 0; dly[1] = TO_A + 6; end
                4: for (int k = 0; k < int'(NS); k++) dly[k] = 0;
                default: begin
                    pick = $urandom_range(0, 7);
                    if (pick == 0) dly[$urandom_range(0, NS - 1)] = TO_A - 1;
                    if (pick == 1) dly[$urandom_range(0, NS - 1)] = $urandom_range(TO_A, TO_A + 20);
                end
            endcase
            compute_schedule();

            endpt = (fa < INF) ? fa : da[NS-1];
            if (db[NS-1] > endpt) endpt = db[NS-1];
            endpt = endpt + $urandom_range(2, 8);
            len   = endpt + 1;
            kind  = $urandom_range(0, 2);
            if (run == 2 || run == 3) kind = 0;
            if (run == 4) begin
                len  = da[0] + 4;
                kind = 1;
            end else if (run >= 5 && $urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, endpt);
            end

            for (int e = 0; e < len; e++) begin
                reset_n        = 1'b1;
                soft_reset_req = 1'b0;
                drive_done(e);
                @(posedge sync_clk);
                @(negedge sync_clk);
                check_model(1'b0, e);
                check_model(1'b1, e);
            end

            reset_n        = (kind == 0);
            soft_reset_req = (kind != 1);
            done_a         = NS'($urandom);
            done_b         = NS'($urandom);
            @(posedge sync_clk);
            @(negedge sync_clk);
            check_reset_values(len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
